// File: rtl/uart_reg_responder_if.sv
// Byte-stream, transmitter-handshake and register-file view shared by the
// responder and whatever drives it (UART RX/TX sides or a testbench).
interface uart_reg_responder_if #(
   parameter int ADDR_W = 4
);
   logic [7:0]                 rx_byte;
   logic                       rx_done;
   logic                       tx_busy;
   logic                       tx_start;
   logic [7:0]                 tx_byte;
   logic                       wr_strobe;
   logic [ADDR_W-1:0]          wr_addr;
   logic [8*(1<<ADDR_W)-1:0]   regs_flat;
   logic [7:0]                 err_cnt;

   modport master (
      output rx_byte, rx_done, tx_busy,
      input  tx_start, tx_byte, wr_strobe, wr_addr, regs_flat, err_cnt
   );

   modport slave (
      input  rx_byte, rx_done, tx_busy,
      output tx_start, tx_byte, wr_strobe, wr_addr, regs_flat, err_cnt
   );
endinterface

// File: rtl/uart_reg_responder.sv
// Decodes 'W' addr data / 'R' addr frames from a UART receiver, executes them
// against a local register file and returns a one-byte reply to the transmitter.
module uart_reg_responder #(
   parameter int          ADDR_W      = 4,
   parameter int          TIMEOUT_CYC = 100000,
   parameter logic [7:0]  ACK         = 8'h06,
   parameter logic [7:0]  NAK         = 8'h15
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   uart_reg_responder_if.slave  bus
);
   localparam int NREG = 1 << ADDR_W;
   localparam int TW   = $clog2(TIMEOUT_CYC + 1);

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ADDR,
      S_GET_DATA,
      S_SEND,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_is_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [7:0]          r_tx_byte;
   logic                r_tx_start;
   logic                r_wr_strobe;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [7:0]          r_err_cnt;
   logic [TW-1:0]       r_tmo_cnt;
   logic [8*NREG-1:0]   w_regs_flat;

   logic                w_err_evt;
   logic                w_reply_load;
   logic [7:0]          w_reply_val;
   logic                w_tx_start_next;
   logic                w_wr_en;
   logic                w_latch_cmd;
   logic                w_latch_addr;
   logic                w_timeout;
   logic                w_addr_ok;
   logic [ADDR_W-1:0]   w_rx_addr;
   logic [7:0]          w_rd_val;

   assign w_rx_addr = bus.rx_byte[ADDR_W-1:0];
   assign w_addr_ok = ((bus.rx_byte >> ADDR_W) == 8'd0);
   assign w_timeout = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
   assign w_rd_val  = w_regs_flat[8*w_rx_addr +: 8];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A byte arriving in the timeout cycle is checked first, so it wins.
   always_comb begin
      w_state_next    = r_state;
      w_err_evt       = 1'b0;
      w_reply_load    = 1'b0;
      w_reply_val     = r_tx_byte;
      w_tx_start_next = 1'b0;
      w_wr_en         = 1'b0;
      w_latch_cmd     = 1'b0;
      w_latch_addr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.rx_done) begin
               if (bus.rx_byte == CMD_W || bus.rx_byte == CMD_R) begin
                  w_latch_cmd  = 1'b1;
                  w_state_next = S_GET_ADDR;
               end else begin
                  w_reply_load = 1'b1;
                  w_reply_val  = NAK;
                  w_err_evt    = 1'b1;
                  w_state_next = S_SEND;
               end
            end
         end
         S_GET_ADDR: begin
            if (bus.rx_done) begin
               if (!w_addr_ok) begin
                  w_reply_load = 1'b1;
                  w_reply_val  = NAK;
                  w_err_evt    = 1'b1;
                  w_state_next = S_SEND;
               end else if (r_is_write) begin
                  w_latch_addr = 1'b1;
                  w_state_next = S_GET_DATA;
               end else begin
                  w_reply_load = 1'b1;
                  w_reply_val  = w_rd_val;
                  w_state_next = S_SEND;
               end
            end else if (w_timeout) begin
               w_err_evt    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_GET_DATA: begin
            if (bus.rx_done) begin
               w_wr_en      = 1'b1;
               w_reply_load = 1'b1;
               w_reply_val  = ACK;
               w_state_next = S_SEND;
            end else if (w_timeout) begin
               w_err_evt    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_SEND: begin
            w_err_evt = bus.rx_done;
            if (!bus.tx_busy) begin
               w_tx_start_next = 1'b1;
               w_state_next    = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            w_err_evt = bus.rx_done;
            if (bus.tx_busy) begin
               w_state_next = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            w_err_evt = bus.rx_done;
            if (!bus.tx_busy) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_is_write  <= 1'b0;
         r_addr      <= '0;
         r_tx_byte   <= 8'h00;
         r_tx_start  <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_err_cnt   <= 8'h00;
         r_tmo_cnt   <= '0;
      end else begin
         r_tx_start  <= w_tx_start_next;
         r_wr_strobe <= w_wr_en;
         if (w_latch_cmd) begin
            r_is_write <= (bus.rx_byte == CMD_W);
         end
         if (w_latch_addr) begin
            r_addr <= w_rx_addr;
         end
         if (w_reply_load) begin
            r_tx_byte <= w_reply_val;
         end
         if (w_wr_en) begin
            r_wr_addr <= r_addr;
         end
         if (w_err_evt && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
         // Counts only while waiting for the next byte of a frame.
         if (bus.rx_done || (w_state_next != S_GET_ADDR && w_state_next != S_GET_DATA)) begin
            r_tmo_cnt <= '0;
         end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
         end
      end
   end

   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [7:0] r_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_q <= 8'h00;
         end else if (w_wr_en && r_addr == ADDR_W'(gi)) begin
            r_q <= bus.rx_byte;
         end
      end
      assign w_regs_flat[8*gi +: 8] = r_q;
   end

   assign bus.tx_start  = r_tx_start;
   assign bus.tx_byte   = r_tx_byte;
   assign bus.wr_strobe = r_wr_strobe;
   assign bus.wr_addr   = r_wr_addr;
   assign bus.regs_flat = w_regs_flat;
   assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench: stimulus queues the expected replies and writes, a monitor
// pops and compares them whenever the responder pulses tx_start or wr_strobe.
module tb_uart_reg_responder;
   localparam int AW   = 4;
   localparam int T    = 40;
   localparam int BUSY = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_reg_responder_if #(.ADDR_W(AW)) bus();

   uart_reg_responder #(.ADDR_W(AW), .TIMEOUT_CYC(T)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_tx[$];
   int         exp_wa[$];
   logic [7:0] exp_wd[$];
   logic       model_en = 1'b1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // Transmitter model: busy for BUSY cycles starting after each tx_start.
   initial begin
      forever begin
         @(negedge clk);
         if (model_en && bus.tx_start === 1'b1) begin
            @(posedge clk);
            #1 bus.tx_busy = 1'b1;
            repeat (BUSY) @(posedge clk);
            #1 bus.tx_busy = 1'b0;
         end
      end
   end

   // Monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            checks++;
            if (bus.tx_busy !== 1'b0) begin
               errors++;
               $display("FAIL tx_start_while_busy actual busy=%b required busy=0", bus.tx_busy);
            end else if (exp_tx.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tx_start actual byte=%0h required no tx_start", bus.tx_byte);
            end else begin
               logic [7:0] e;
               e = exp_tx.pop_front();
               if (bus.tx_byte !== e) begin
                  errors++;
                  $display("FAIL tx_byte actual=%0h required=%0h", bus.tx_byte, e);
               end else begin
                  $display("ok   reply tx_byte = %0h", bus.tx_byte);
               end
            end
         end
         if (bus.wr_strobe === 1'b1) begin
            checks++;
            if (exp_wa.size() == 0) begin
               errors++;
               $display("FAIL unexpected_wr_strobe actual addr=%0h required no strobe", bus.wr_addr);
            end else begin
               int         a;
               logic [7:0] d;
               a = exp_wa.pop_front();
               d = exp_wd.pop_front();
               if (bus.wr_addr !== AW'(a) || bus.regs_flat[8*a +: 8] !== d) begin
                  errors++;
                  $display("FAIL write actual addr=%0h data=%0h required addr=%0h data=%0h",
                           bus.wr_addr, bus.regs_flat[8*a +: 8], a, d);
               end else begin
                  $display("ok   write reg[%0h] = %0h", a, d);
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk);
      #1;
      bus.rx_byte = b;
      bus.rx_done = 1'b1;
      @(posedge clk);
      #1 bus.rx_done = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_tx.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_tx.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL reply_timeout actual pending=%0d required 0", exp_tx.size());
         exp_tx.delete();
      end
      repeat (BUSY + 6) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n;
      bus.rx_byte = 8'h00;
      bus.rx_done = 1'b0;
      bus.tx_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_start", 128'(bus.tx_start), 128'd0);
      chk("rst_tx_byte", 128'(bus.tx_byte), 128'd0);
      chk("rst_wr_strobe", 128'(bus.wr_strobe), 128'd0);
      chk("rst_wr_addr", 128'(bus.wr_addr), 128'd0);
      chk("rst_regs_flat", bus.regs_flat, 128'd0);
      chk("rst_err_cnt", 128'(bus.err_cnt), 128'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Write then read back.
      exp_wa.push_back(3); exp_wd.push_back(8'hA5); exp_tx.push_back(8'h06);
      send_byte(8'h57, 0); send_byte(8'h03, 0); send_byte(8'hA5, 0);
      wait_idle();
      chk("write_reg3", 128'(bus.regs_flat[31:24]), 128'hA5);
      exp_tx.push_back(8'hA5);
      send_byte(8'h52, 0); send_byte(8'h03, 0);
      wait_idle();
      chk("read_err_cnt", 128'(bus.err_cnt), 128'd0);

      // Reply held off while the transmitter is busy.
      model_en = 1'b0;
      bus.tx_busy = 1'b1;
      exp_tx.push_back(8'hA5);
      send_byte(8'h52, 0); send_byte(8'h03, 0);
      repeat (10) @(negedge clk);
      chk("held_reply_pending", 128'(exp_tx.size()), 128'd1);
      model_en = 1'b1;
      bus.tx_busy = 1'b0;
      @(negedge clk);
      bus.tx_busy = 1'b1;
      repeat (3) @(negedge clk);
      bus.tx_busy = 1'b0;
      wait_idle();

      // Bad command, then a read still works.
      exp_tx.push_back(8'h15);
      send_byte(8'h41, 0);
      wait_idle();
      chk("badcmd_err_cnt", 128'(bus.err_cnt), 128'd1);
      exp_tx.push_back(8'hA5);
      send_byte(8'h52, 0); send_byte(8'h03, 0);
      wait_idle();

      // Out-of-range address; trailing data byte lands during the reply.
      do_reset();
      exp_tx.push_back(8'h15);
      send_byte(8'h57, 0); send_byte(8'h10, 2); send_byte(8'h77, 0);
      wait_idle();
      chk("oor_err_cnt", 128'(bus.err_cnt), 128'd2);
      chk("oor_regs", bus.regs_flat, 128'd0);

      // Partial frame times out silently.
      do_reset();
      send_byte(8'h57, 0); send_byte(8'h02, 0);
      repeat (T + 5) @(negedge clk);
      chk("timeout_err_cnt", 128'(bus.err_cnt), 128'd1);
      exp_tx.push_back(8'h00);
      send_byte(8'h52, 0); send_byte(8'h02, 0);
      wait_idle();

      // Bytes arriving exactly in the timeout cycle keep the frame alive.
      exp_wa.push_back(5); exp_wd.push_back(8'h3C); exp_tx.push_back(8'h06);
      send_byte(8'h57, T - 2); send_byte(8'h05, T - 2); send_byte(8'h3C, 0);
      wait_idle();
      chk("edge_err_cnt", 128'(bus.err_cnt), 128'd1);
      chk("edge_reg5", 128'(bus.regs_flat[47:40]), 128'h3C);

      // Reset in the middle of the ACK transmission.
      exp_wa.push_back(4); exp_wd.push_back(8'h99); exp_tx.push_back(8'h06);
      send_byte(8'h57, 0); send_byte(8'h04, 0); send_byte(8'h99, 0);
      n = 0;
      while (bus.tx_busy !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("midreply_busy_seen", 128'(bus.tx_busy), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("midreply_tx_byte", 128'(bus.tx_byte), 128'd0);
      chk("midreply_wr_addr", 128'(bus.wr_addr), 128'd0);
      chk("midreply_regs", bus.regs_flat, 128'd0);
      chk("midreply_err_cnt", 128'(bus.err_cnt), 128'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      chk("pending_replies", 128'(exp_tx.size()), 128'd0);
      chk("pending_writes", 128'(exp_wa.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
